sp_ram_arbiter: RTL and testbench

- Two-requester controller that shares one single-port synchronous RAM (add_wd/data_wd geometry) between ports A and B.
- Arbitrates round-robin and issues one registered command per grant to the RAM.
- Sequences each access (write = 2 cycles, read = 3 cycles), captures RAM read data one cycle after the RAM samples the read, and returns it to the winner with a valid pulse.
- Sits between two bus masters and the RAM instance; nothing else drives the RAM.

---
 rtl/sp_ram_arbiter_if.sv | 50 +++++
 rtl/sp_ram_arbiter.sv | 138 +++++++++++++
 tb/tb_sp_ram_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sp_ram_arbiter_if.sv
// Bus bundle for sp_ram_arbiter: requester ports A/B, RAM side, busy.
// slave = arbiter view, master = requesters + RAM view.
interface sp_ram_arbiter_if #(
  parameter int add_wd  = 4,
  parameter int data_wd = 32
);
  logic               a_req;
  logic               a_rnw;
  logic [add_wd-1:0]  a_add;
  logic [data_wd-1:0] a_wr_data;
  logic               a_gnt;
  logic               a_rd_valid;
  logic [data_wd-1:0] a_rd_data;

  logic               b_req;
  logic               b_rnw;
  logic [add_wd-1:0]  b_add;
  logic [data_wd-1:0] b_wr_data;
  logic               b_gnt;
  logic               b_rd_valid;
  logic [data_wd-1:0] b_rd_data;

  logic               ram_cs;
  logic               ram_rnw;
  logic [add_wd-1:0]  ram_add;
  logic [data_wd-1:0] ram_wr_data;
  logic [data_wd-1:0] ram_rd_data;

  logic               busy;

  modport slave (
    input  a_req, a_rnw, a_add, a_wr_data,
    output a_gnt, a_rd_valid, a_rd_data,
    input  b_req, b_rnw, b_add, b_wr_data,
    output b_gnt, b_rd_valid, b_rd_data,
    output ram_cs, ram_rnw, ram_add, ram_wr_data,
    input  ram_rd_data,
    output busy
  );

  modport master (
    output a_req, a_rnw, a_add, a_wr_data,
    input  a_gnt, a_rd_valid, a_rd_data,
    output b_req, b_rnw, b_add, b_wr_data,
    input  b_gnt, b_rd_valid, b_rd_data,
    input  ram_cs, ram_rnw, ram_add, ram_wr_data,
    output ram_rd_data,
    input  busy
  );
endinterface

// File: rtl/sp_ram_arbiter.sv
// Two-port round-robin arbiter in front of one single-port sync RAM.
// Ports: clk, rst (sync, active-high), bus (sp_ram_arbiter_if.slave).
// Macro SP_RAM_ARB_FIXED_PRIO_EN: A always wins ties (B may starve).
module sp_ram_arbiter #(
  parameter int add_wd  = 4,
  parameter int data_wd = 32
) (
  input logic clk,
  input logic rst,
  sp_ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDWAIT
  } state_e;

  state_e             state_q, state_d;
  logic               win_q, win_d;
  logic               last_q, last_d;
  logic               a_gnt_q, a_gnt_d;
  logic               b_gnt_q, b_gnt_d;
  logic               a_vld_q, a_vld_d;
  logic               b_vld_q, b_vld_d;
  logic [data_wd-1:0] a_rdd_q, a_rdd_d;
  logic [data_wd-1:0] b_rdd_q, b_rdd_d;
  logic               cs_q, cs_d;
  logic               rnw_q, rnw_d;
  logic [add_wd-1:0]  add_q, add_d;
  logic [data_wd-1:0] wd_q, wd_d;
  logic               busy_q, busy_d;
  logic               pick_b;

  // win/last encoding: 0 = A, 1 = B
  always_comb begin
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
    pick_b = bus.b_req & ~bus.a_req;
`else
    pick_b = bus.b_req & (~bus.a_req | ~last_q);
`endif
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    a_gnt_d = 1'b0;
    b_gnt_d = 1'b0;
    a_vld_d = 1'b0;
    b_vld_d = 1'b0;
    a_rdd_d = a_rdd_q;
    b_rdd_d = b_rdd_q;
    cs_d    = 1'b0;
    rnw_d   = rnw_q;
    add_d   = add_q;
    wd_d    = wd_q;
    unique case (state_q)
      IDLE: begin
        if (bus.a_req | bus.b_req) begin
          state_d = ISSUE;
          win_d   = pick_b;
          last_d  = pick_b;
          cs_d    = 1'b1;
          a_gnt_d = ~pick_b;
          b_gnt_d = pick_b;
          rnw_d   = pick_b ? bus.b_rnw : bus.a_rnw;
          add_d   = pick_b ? bus.b_add : bus.a_add;
          wd_d    = pick_b ? bus.b_wr_data
                           : bus.a_wr_data;
        end
      end
      ISSUE: begin
        state_d = rnw_q ? RDWAIT : IDLE;
      end
      RDWAIT: begin
        // RAM data is only valid here
        state_d = IDLE;
        if (win_q) begin
          b_vld_d = 1'b1;
          b_rdd_d = bus.ram_rd_data;
        end else begin
          a_vld_d = 1'b1;
          a_rdd_d = bus.ram_rd_data;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      a_gnt_q <= 1'b0;
      b_gnt_q <= 1'b0;
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
      a_rdd_q <= '0;
      b_rdd_q <= '0;
      cs_q    <= 1'b0;
      rnw_q   <= 1'b0;
      add_q   <= '0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      a_gnt_q <= a_gnt_d;
      b_gnt_q <= b_gnt_d;
      a_vld_q <= a_vld_d;
      b_vld_q <= b_vld_d;
      a_rdd_q <= a_rdd_d;
      b_rdd_q <= b_rdd_d;
      cs_q    <= cs_d;
      rnw_q   <= rnw_d;
      add_q   <= add_d;
      wd_q    <= wd_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.a_gnt       = a_gnt_q;
  assign bus.b_gnt       = b_gnt_q;
  assign bus.a_rd_valid  = a_vld_q;
  assign bus.b_rd_valid  = b_vld_q;
  assign bus.a_rd_data   = a_rdd_q;
  assign bus.b_rd_data   = b_rdd_q;
  assign bus.ram_cs      = cs_q;
  assign bus.ram_rnw     = rnw_q;
  assign bus.ram_add     = add_q;
  assign bus.ram_wr_data = wd_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Self-checking bench for sp_ram_arbiter with a behavioural RAM and
// a memory/arbitration reference model.
module tb_sp_ram_arbiter;
  localparam int AW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sp_ram_arbiter_if #(.add_wd(AW), .data_wd(DW)) bus ();

  sp_ram_arbiter #(.add_wd(AW), .data_wd(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // behavioural single-port synchronous RAM
  logic [DW-1:0] ram_mem [16];
  logic [DW-1:0] ram_rd_q;
  always @(posedge clk) begin
    if (bus.ram_cs) begin
      if (bus.ram_rnw) ram_rd_q <= ram_mem[bus.ram_add];
      else ram_mem[bus.ram_add] <= bus.ram_wr_data;
    end
  end
  assign bus.ram_rd_data = ram_rd_q;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: memory contents and who was served last
  logic [DW-1:0] mdl [16];
  int last_srv;  // 0 = A, 1 = B

  function automatic int exp_winner(bit ra, bit rb);
    if (ra && !rb) return 0;
    if (rb && !ra) return 1;
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
    return 0;
`else
    return (last_srv == 0) ? 1 : 0;
`endif
  endfunction

  task automatic set_a(bit req, bit rnw, logic [AW-1:0] add,
                       logic [DW-1:0] d);
    bus.a_req = req; bus.a_rnw = rnw;
    bus.a_add = add; bus.a_wr_data = d;
  endtask

  task automatic set_b(bit req, bit rnw, logic [AW-1:0] add,
                       logic [DW-1:0] d);
    bus.b_req = req; bus.b_rnw = rnw;
    bus.b_add = add; bus.b_wr_data = d;
  endtask

  // returns 0 = A, 1 = B, 2 = both, -1 = none within max cycles
  task automatic wait_gnt(input int max, output int which);
    which = -1;
    for (int i = 0; i < max && which < 0; i++) begin
      @(posedge clk); #1;
      if (bus.a_gnt && bus.b_gnt) which = 2;
      else if (bus.a_gnt) which = 0;
      else if (bus.b_gnt) which = 1;
    end
  endtask

  task automatic pulse_rst;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_srv = 1;
  endtask

  task automatic test_reset;
    set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.ram_cs, bus.ram_rnw, bus.a_gnt, bus.b_gnt,
         bus.a_rd_valid, bus.b_rd_valid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 0000000",
        {bus.busy, bus.ram_cs, bus.ram_rnw, bus.a_gnt, bus.b_gnt,
         bus.a_rd_valid, bus.b_rd_valid});
    end
    checks++;
    if (bus.ram_add !== '0 || bus.ram_wr_data !== '0) begin
      errors++;
      $display("FAIL reset_ram: add %h wd %h want 0",
        bus.ram_add, bus.ram_wr_data);
    end
    checks++;
    if (bus.a_rd_data !== '0 || bus.b_rd_data !== '0) begin
      errors++;
      $display("FAIL reset_rdd: a %h b %h want 0",
        bus.a_rd_data, bus.b_rd_data);
    end
    rst = 1'b0;
    last_srv = 1;
  endtask

  task automatic test_write_a;
    int w;
    set_a(1, 0, 3, 32'hDEADBEEF);
    wait_gnt(10, w);
    checks++;
    if (w !== 0) begin
      errors++; $display("FAIL wr_a_gnt: got %0d want 0", w);
    end
    checks++;
    if (bus.ram_cs !== 1'b1 || bus.ram_rnw !== 1'b0 ||
        bus.ram_add !== 4'd3 || bus.ram_wr_data !== 32'hDEADBEEF ||
        bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_a_cmd: cs %b rnw %b add %h wd %h busy %b",
        bus.ram_cs, bus.ram_rnw, bus.ram_add, bus.ram_wr_data, bus.busy);
    end
    set_a(0, 0, 0, 0);
    mdl[3] = 32'hDEADBEEF;
    last_srv = 0;
    @(posedge clk); #1;
    checks++;
    if (bus.a_gnt !== 1'b0 || bus.ram_cs !== 1'b0 ||
        bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_a_end: gnt %b cs %b busy %b want 000",
        bus.a_gnt, bus.ram_cs, bus.busy);
    end
  endtask

  task automatic test_read_a;
    int w;
    set_a(1, 1, 3, $urandom);
    wait_gnt(10, w);
    checks++;
    if (w !== 0) begin
      errors++; $display("FAIL rd_a_gnt: got %0d want 0", w);
    end
    set_a(0, 0, 0, 0);
    last_srv = 0;
    @(posedge clk); #1;
    checks++;
    if (bus.a_rd_valid !== 1'b0) begin
      errors++; $display("FAIL rd_a_early: valid %b want 0", bus.a_rd_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.a_rd_valid !== 1'b1 || bus.a_rd_data !== mdl[3] ||
        bus.b_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_a_data: av %b bv %b data %h want 1 0 %h",
        bus.a_rd_valid, bus.b_rd_valid, bus.a_rd_data, mdl[3]);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.a_rd_valid !== 1'b0 || bus.a_rd_data !== mdl[3]) begin
      errors++;
      $display("FAIL rd_a_hold: valid %b data %h want 0 %h",
        bus.a_rd_valid, bus.a_rd_data, mdl[3]);
    end
  endtask

  task automatic test_preload;
    int w;
    int p;
    logic [DW-1:0] d;
    int bad = 0;
    for (int i = 0; i < 16; i++) begin
      p = int'($urandom_range(0, 1));
      d = $urandom | 32'h1;
      if (p == 0) set_a(1, 0, AW'(i), d);
      else set_b(1, 0, AW'(i), d);
      wait_gnt(10, w);
      if (w !== p) bad++;
      set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
      mdl[i] = d;
      last_srv = p;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL preload_gnt: %0d wrong grants want 0", bad);
    end
  endtask

  task automatic test_contention;
    int w;
    int e;
    pulse_rst;
    set_a(1, 1, 1, $urandom);
    set_b(1, 1, 2, $urandom);
    for (int k = 0; k < 4; k++) begin
      e = exp_winner(1, 1);
      wait_gnt(10, w);
      checks++;
      if (w !== e) begin
        errors++;
        $display("FAIL cont_order%0d: got %0d want %0d", k, w, e);
      end
      last_srv = e;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (e == 0 ? (bus.a_rd_valid !== 1'b1 || bus.a_rd_data !== mdl[1])
                 : (bus.b_rd_valid !== 1'b1 || bus.b_rd_data !== mdl[2]))
      begin
        errors++;
        $display("FAIL cont_data%0d: av %b ad %h bv %b bd %h", k,
          bus.a_rd_valid, bus.a_rd_data, bus.b_rd_valid, bus.b_rd_data);
      end
    end
    set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_write_then_read;
    int w;
    int tg;
    logic [DW-1:0] old;
    set_b(1, 0, 5, 32'h12345678);
    wait_gnt(10, w);
    tg = cyc;
    checks++;
    if (w !== 1) begin
      errors++; $display("FAIL wtr_bgnt: got %0d want 1", w);
    end
    set_b(0, 0, 0, 0);
    set_a(1, 1, 5, 0);
    mdl[5] = 32'h12345678;
    last_srv = 1;
    wait_gnt(10, w);
    checks++;
    if (w !== 0 || cyc - tg != 2) begin
      errors++;
      $display("FAIL wtr_agnt: got %0d after %0d want 0 after 2",
        w, cyc - tg);
    end
    set_a(0, 0, 0, 0);
    last_srv = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.a_rd_valid !== 1'b1 || bus.a_rd_data !== mdl[5]) begin
      errors++;
      $display("FAIL wtr_data: valid %b data %h want 1 %h",
        bus.a_rd_valid, bus.a_rd_data, mdl[5]);
    end
    // read then write same address: read sees old data
    old = mdl[7];
    set_a(1, 1, 7, 0);
    wait_gnt(10, w);
    set_a(0, 0, 0, 0);
    set_b(1, 0, 7, ~old);
    last_srv = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (w !== 0 || bus.a_rd_valid !== 1'b1 || bus.a_rd_data !== old) begin
      errors++;
      $display("FAIL rtw_old: gnt %0d valid %b data %h want 0 1 %h",
        w, bus.a_rd_valid, bus.a_rd_data, old);
    end
    wait_gnt(10, w);
    set_b(0, 0, 0, 0);
    mdl[7] = ~old;
    last_srv = 1;
    checks++;
    if (w !== 1) begin
      errors++; $display("FAIL rtw_bgnt: got %0d want 1", w);
    end
  endtask

  task automatic test_reset_mid;
    int w;
    int seen = 0;
    set_b(1, 1, 2, 0);
    wait_gnt(10, w);
    set_b(0, 0, 0, 0);
    last_srv = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (w !== 1 || bus.b_rd_data !== mdl[2]) begin
      errors++;
      $display("FAIL rstm_pre: gnt %0d data %h want 1 %h",
        w, bus.b_rd_data, mdl[2]);
    end
    set_b(1, 1, 9, 0);
    wait_gnt(10, w);
    set_b(0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.ram_cs !== 1'b0 ||
        bus.b_rd_valid !== 1'b0 || bus.b_rd_data !== '0) begin
      errors++;
      $display("FAIL rstm_state: busy %b cs %b bv %b bd %h want 0 0 0 0",
        bus.busy, bus.ram_cs, bus.b_rd_valid, bus.b_rd_data);
    end
    rst = 1'b0;
    last_srv = 1;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.b_rd_valid !== 1'b0 || bus.ram_cs !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL rstm_after: %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    int w;
    int prev = 0;
    logic [DW-1:0] d [3];
    for (int i = 0; i < 3; i++) d[i] = $urandom;
    set_b(1, 0, 0, d[0]);
    for (int i = 0; i < 3; i++) begin
      wait_gnt(10, w);
      checks++;
      if (w !== 1 || (i > 0 && cyc - prev != 2)) begin
        errors++;
        $display("FAIL b2b_gnt%0d: got %0d gap %0d want 1 gap 2",
          i, w, cyc - prev);
      end
      prev = cyc;
      mdl[i] = d[i];
      last_srv = 1;
      if (i < 2) set_b(1, 0, AW'(i + 1), d[i + 1]);
      else set_b(0, 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      set_b(1, 1, AW'(i), 0);
      wait_gnt(10, w);
      set_b(0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (w !== 1 || bus.b_rd_valid !== 1'b1 || bus.b_rd_data !== mdl[i])
      begin
        errors++;
        $display("FAIL b2b_rd%0d: gnt %0d valid %b data %h want 1 1 %h",
          i, w, bus.b_rd_valid, bus.b_rd_data, mdl[i]);
      end
    end
  endtask

  task automatic test_random;
    int w;
    int e;
    bit pa, pb;
    bit ar, br;
    logic [AW-1:0] aa, ba;
    logic [DW-1:0] ad, bd, ed;
    int bad = 0;
    for (int r = 0; r < 40 && bad == 0; r++) begin
      pa = 1'($urandom); pb = 1'($urandom);
      if (!pa && !pb) pa = 1;
      ar = 1'($urandom); br = 1'($urandom);
      aa = AW'($urandom); ba = AW'($urandom);
      ad = $urandom; bd = $urandom;
      set_a(pa, ar, aa, ad);
      set_b(pb, br, ba, bd);
      for (int g = 0; g < 2 && (pa || pb) && bad == 0; g++) begin
        e = exp_winner(pa, pb);
        wait_gnt(10, w);
        checks++;
        if (w !== e) begin
          errors++; bad++;
          $display("FAIL rnd_gnt r%0d: got %0d want %0d", r, w, e);
        end
        last_srv = e;
        if (e == 0) begin
          pa = 0; set_a(0, 0, 0, 0);
          ed = mdl[aa];
          if (!ar) mdl[aa] = ad;
        end else begin
          pb = 0; set_b(0, 0, 0, 0);
          ed = mdl[ba];
          if (!br) mdl[ba] = bd;
        end
        if (e == 0 ? ar : br) begin
          repeat (2) @(posedge clk);
          #1;
          checks++;
          if (e == 0 ? (bus.a_rd_valid !== 1'b1 || bus.a_rd_data !== ed)
                     : (bus.b_rd_valid !== 1'b1 || bus.b_rd_data !== ed))
          begin
            errors++; bad++;
            $display("FAIL rnd_rd r%0d: av %b ad %h bv %b bd %h want %h",
              r, bus.a_rd_valid, bus.a_rd_data,
              bus.b_rd_valid, bus.b_rd_data, ed);
          end
        end
      end
    end
    set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
  endtask

  initial begin
    last_srv = 1;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    test_reset;
    test_write_a;
    test_read_a;
    test_preload;
    test_contention;
    test_write_then_read;
    test_reset_mid;
    test_back_to_back;
    test_random;
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
